// File: rtl/dcache_flush_arbiter_if.sv
// Flush-arbiter bundle: requester handshake, DCache flush handshake and watchdog status.
// The arbiter takes the slave view; the requester/DCache side takes the master view.
interface dcache_flush_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 16
);
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic [NUM_REQ-1:0]   done_o;
  logic                 flush_dcache_o;
  logic                 flush_dcache_ack_i;
  logic [TIMEOUT_W-1:0] timeout_cycles_i;
  logic                 busy_o;
  logic                 timeout_o;

  modport slave (
    input  req_i, flush_dcache_ack_i, timeout_cycles_i,
    output gnt_o, done_o, flush_dcache_o, busy_o, timeout_o
  );

  modport master (
    output req_i, flush_dcache_ack_i, timeout_cycles_i,
    input  gnt_o, done_o, flush_dcache_o, busy_o, timeout_o
  );
endinterface

// File: rtl/dcache_flush_arbiter.sv
// Round-robin arbiter sharing one DCache flush handshake among NUM_REQ requesters, with watchdog.
// Define DCACHE_FLUSH_COALESCE_EN to grant all pending requesters together on a single flush.
module dcache_flush_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  dcache_flush_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 flush_q, flush_d;
  logic                 timeout_q, timeout_d;
  logic                 wdog_hit;

  // First asserted request scanning from ptr upward with wrap-around.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
    logic [NUM_REQ-1:0] onehot;
    logic               found;
    int                 idx;
    onehot = '0;
    found  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [NUM_REQ-1:0] onehot,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] nxt;
    nxt = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) nxt = IDX_W'((i + 1) % NUM_REQ);
    end
    return nxt;
  endfunction

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + TIMEOUT_W'(1);
  endfunction

  // Limit of zero disables the watchdog; otherwise fire once the count reaches limit-1.
  assign wdog_hit = (bus.timeout_cycles_i != '0) &&
                    (wdog_q == bus.timeout_cycles_i - TIMEOUT_W'(1));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    wdog_d    = wdog_q;
    gnt_d     = '0;
    done_d    = '0;
    flush_d   = flush_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (|bus.req_i) begin
`ifdef DCACHE_FLUSH_COALESCE_EN
          owner_d = bus.req_i;
`else
          owner_d = rr_pick(bus.req_i, rr_q);
          rr_d    = rr_next(owner_d, rr_q);
`endif
          gnt_d     = owner_d;
          flush_d   = 1'b1;
          wdog_d    = '0;
          timeout_d = 1'b0;
          state_d   = FLUSH;
        end
      end

      FLUSH: begin
        flush_d = 1'b1;
        wdog_d  = sat_inc(wdog_q);
        if (wdog_hit) timeout_d = 1'b1;
        if (bus.flush_dcache_ack_i) begin
          flush_d = 1'b0;
          done_d  = owner_q;
          state_d = DONE;
        end
      end

      DONE: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Clear and reset are equivalent; an in-flight flush is abandoned without a done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      wdog_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      wdog_q    <= wdog_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt_o          = gnt_q;
  assign bus.done_o         = done_q;
  assign bus.flush_dcache_o = flush_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// Directed bench for dcache_flush_arbiter: per-cycle vector table plus hand sequences
// for watchdog, disabled watchdog, reset and clear during a flush.
module tb_dcache_flush_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT_W = 16;
`ifdef DCACHE_FLUSH_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  logic clr_i  = 1'b0;

  always #5 clk = ~clk;

  dcache_flush_arbiter_if #(.NUM_REQ(NUM_REQ), .TIMEOUT_W(TIMEOUT_W)) bus ();

  dcache_flush_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .bus    (bus)
  );

  // Inputs driven during a cycle; outputs expected right after the closing edge.
  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       flush;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [10:0] outs();
    return {bus.gnt_o, bus.done_o, bus.flush_dcache_o, bus.busy_o, bus.timeout_o};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (gnt,done,flush,busy,timeout)", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic ack);
    bus.req_i              = req;
    bus.flush_dcache_ack_i = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] req, input logic ack, input logic [3:0] gnt,
                     input logic [3:0] done, input logic flush, input logic busy);
    vec_t v;
    v.req = req; v.ack = ack; v.gnt = gnt; v.done = done;
    v.flush = flush; v.busy = busy; v.tmo = 1'b0;
    tbl.push_back(v);
  endtask

  logic seen_tmo;

  initial begin
    bus.req_i              = '0;
    bus.flush_dcache_ack_i = 1'b0;
    bus.timeout_cycles_i   = '0;

    step(4'b0000, 1'b0);
    step(4'b1111, 1'b1);
    check("reset_state", outs(), 11'b0);
    rst_ni = 1'b1;

`ifdef DCACHE_FLUSH_COALESCE_EN
    add(4'b0110, 0, 4'b0110, 4'b0000, 1, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0000, 1, 4'b0000, 4'b0110, 0, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
`else
    // Round-robin 0,1,2,3 with acks in the grant cycle.
    add(4'b1111, 0, 4'b0001, 4'b0000, 1, 1);
    add(4'b1110, 1, 4'b0000, 4'b0001, 0, 1);
    add(4'b1110, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1110, 0, 4'b0010, 4'b0000, 1, 1);
    add(4'b1100, 1, 4'b0000, 4'b0010, 0, 1);
    add(4'b1100, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1100, 0, 4'b0100, 4'b0000, 1, 1);
    add(4'b1000, 1, 4'b0000, 4'b0100, 0, 1);
    add(4'b1000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 0, 4'b1000, 4'b0000, 1, 1);
    add(4'b0000, 1, 4'b0000, 4'b1000, 0, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    // 4'b1001 from pointer 0: grant 0 then 3.
    add(4'b1001, 0, 4'b0001, 4'b0000, 1, 1);
    add(4'b1000, 1, 4'b0000, 4'b0001, 0, 1);
    add(4'b1000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 0, 4'b1000, 4'b0000, 1, 1);
    add(4'b0000, 1, 4'b0000, 4'b1000, 0, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
`endif
    // Ack while idle is ignored.
    add(4'b0000, 1, 4'b0000, 4'b0000, 0, 0);
    // Single request, ack in cycle 5; requester 0 raises during the flush and waits.
    add(4'b0100, 0, 4'b0100, 4'b0000, 1, 1);
    add(4'b0001, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0001, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0001, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0001, 0, 4'b0000, 4'b0000, 1, 1);
    add(4'b0001, 1, 4'b0000, 4'b0100, 0, 1);
    add(4'b0001, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0001, 0, 4'b0001, 4'b0000, 1, 1);
    add(4'b0000, 1, 4'b0000, 4'b0001, 0, 1);
    add(4'b0000, 0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].ack);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].gnt, tbl[i].done, tbl[i].flush, tbl[i].busy, tbl[i].tmo});
    end

    // Watchdog limit 8: flag visible after 8 flush cycles, cleared by the next grant.
    bus.timeout_cycles_i = 16'd8;
    step(4'b0010, 1'b0);
    check("wd_grant", outs(), {4'b0010, 4'b0000, 3'b110});
    for (int c = 2; c <= 8; c++) step(4'b0000, 1'b0);
    check("wd_cycle8", outs(), {8'b0, 3'b110});
    step(4'b0000, 1'b0);
    check("wd_set", outs(), {8'b0, 3'b111});
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);
    check("wd_sticky", outs(), {8'b0, 3'b111});
    step(4'b0000, 1'b1);
    check("wd_done", outs(), {4'b0000, 4'b0010, 3'b011});
    step(4'b0000, 1'b0);
    check("wd_idle_keep", outs(), {8'b0, 3'b001});
    step(4'b0001, 1'b0);
    check("wd_clear_on_gnt", outs(), {4'b0001, 4'b0000, 3'b110});
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Watchdog disabled: 1000 cycles with no ack never raise the flag.
    bus.timeout_cycles_i = '0;
    step(4'b0100, 1'b0);
    seen_tmo = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step(4'b0000, 1'b0);
      seen_tmo |= bus.timeout_o;
    end
    check("wd_disabled", {9'b0, seen_tmo, bus.flush_dcache_o}, 11'b01);
    step(4'b0000, 1'b1);
    check("wd_disabled_done", outs(), {4'b0000, 4'b0100, 3'b010});
    step(4'b0000, 1'b0);

    // Reset in mid-flush: everything drops, no done, pointer back to 0.
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    rst_ni = 1'b0;
    step(4'b0000, 1'b1);
    check("rst_mid_flush", outs(), 11'b0);
    rst_ni = 1'b1;
    step(4'b0000, 1'b1);
    check("rst_no_done", outs(), 11'b0);
    step(4'b1111, 1'b0);
    check("rst_rr_zero", outs(), {(COAL ? 4'b1111 : 4'b0001), 4'b0000, 3'b110});
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Clear in mid-flush behaves like reset.
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    clr_i = 1'b1;
    step(4'b0000, 1'b1);
    check("clr_mid_flush", outs(), 11'b0);
    clr_i = 1'b0;
    step(4'b0000, 1'b0);
    check("clr_no_done", outs(), 11'b0);
    step(4'b1010, 1'b0);
    check("clr_rr_zero", outs(), {(COAL ? 4'b1010 : 4'b0010), 4'b0000, 3'b110});
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
